seq_hist_reg: RTL and testbench
===============================

Name: seq_hist_reg

Overview:
Parametrised history shift register for LSTM training. During forward propagation it records one NUM_CH×WIDTH vector per time step. During backpropagation-through-time it returns those vectors in reverse order (LIFO pop).
Unlike a plain shift register it adds:
- push/pop control
- occupancy count and full/empty flags
- overflow/underflow flags
- synchronous clear
Sits between the LSTM cell datapath (h, c, gate activations) and the BPTT gradient unit.

Parameters:
NUM_ITERATIONS, 68, depth in time steps (≥2)
WIDTH, 32, bits per signed word
NUM_CH, 1, words per time step (e.g. hidden units stored in parallel)
CW, $clog2(NUM_ITERATIONS+1), count width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
clr  in  1  synchronous clear of contents and flags
push  in  1  store i as newest entry this cycle
pop  in  1  consume newest entry this cycle
i  in  NUM_CH*WIDTH  signed input vector
o  out  NUM_ITERATIONS*NUM_CH*WIDTH  full parallel contents; slot k = o[(k+1)*NUM_CH*WIDTH-1 -: NUM_CH*WIDTH]
o_top  out  NUM_CH*WIDTH  slot NUM_ITERATIONS-1 (newest entry)
count  out  CW  number of valid entries
empty  out  1  count==0
full  out  1  count==NUM_ITERATIONS
ovf  out  1  sticky: push while full dropped an entry
unf  out  1  sticky: pop while empty

Behaviour:
- Storage: NUM_ITERATIONS slots. Slot NUM_ITERATIONS-1 is the newest and slot 0 the oldest, so valid entries occupy the top `count` slots.
- All outputs are registered state or direct decodes of it. empty/full are combinational from count. No output has an input-to-output combinational path.
- Priority: rst > clr > push/pop.
- rst or clr, next edge:
  - all slots = 0, count = 0, ovf = 0, unf = 0
  - therefore o = 0, o_top = 0, empty = 1, full = 0
  - Reset mid-operation discards everything; there is no partial state.
- push only:
  - slot k ← slot k+1 for k < NUM_ITERATIONS-1; slot NUM_ITERATIONS-1 ← i
  - count ← min(count+1, NUM_ITERATIONS)
  - If full, the oldest entry (slot 0) is lost, count stays NUM_ITERATIONS, and ovf ← 1.
- pop only, not empty:
  - Before the edge, o_top holds the entry being consumed (zero read latency).
  - At the edge: slot k+1 ← slot k for k < NUM_ITERATIONS-1; slot 0 ← 0; count ← count-1.
- pop only, empty: no data or count change; unf ← 1.
- push and pop together:
  - Not empty: slot NUM_ITERATIONS-1 ← i, other slots unchanged, count unchanged (replace newest).
  - Empty: behaves as push only; unf not set.
  - Full: replace newest; ovf not set.
- Neither push nor pop: state holds.
- ovf/unf stay set until rst or clr.
- Data is passed through bit-exact; there is no arithmetic, sign extension or saturation on data. count arithmetic never wraps.
- Invalid slots always read 0. Pop zero-fill and reset guarantee this.

Test Plan:
Bench config for all scenarios: NUM_ITERATIONS=4, WIDTH=8, NUM_CH=1.
1. rst=1 one cycle with arbitrary prior contents → o=0, count=0, empty=1, full=0, ovf=unf=0 on the following cycle.
2. Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles → o slots[3..0]=44,33,22,11; count=4; full=1. Then push 0x55 → slots=55,44,33,22; count=4; ovf=1.
3. From state 55,44,33,22: pop four times → o_top before each edge reads 55, 44, 33, 22; then count=0, empty=1, o=0. A fifth pop → unf=1, o unchanged.
4. Slots 33,22 (count=2): push=pop=1 with i=0x7F → slots[3..2]=7F,22, count=2. On empty: push=pop=1 with i=0x80 → slot3=80, count=1, unf=0.
5. Count=3 with ovf=1: assert clr together with push (i=0x99) → next cycle all zero, count=0, ovf=0; push ignored. Assert rst and clr together → reset result.
6. Randomised push/pop for 1000 cycles against a LIFO reference model of depth 4 → o, o_top, count and flags match every cycle.

Source files
------------

// File: rtl/seq_hist_reg_if.sv
// Bundle for the history register: control strobes, input vector, and
// registered contents/status. The user side (master) drives clr, push,
// pop and i. The register side (slave) returns the stored vectors and flags.
interface seq_hist_reg_if #(
   parameter int NUM_ITERATIONS = 68,
   parameter int WIDTH          = 32,
   parameter int NUM_CH         = 1
);
   localparam int VW = NUM_CH * WIDTH;
   localparam int CW = $clog2(NUM_ITERATIONS + 1);

   logic                             clr;
   logic                             push;
   logic                             pop;
   logic [VW-1:0]                    i;
   logic [NUM_ITERATIONS*VW-1:0]     o;
   logic [VW-1:0]                    o_top;
   logic [CW-1:0]                    count;
   logic                             empty;
   logic                             full;
   logic                             ovf;
   logic                             unf;

   modport master (
      output clr, push, pop, i,
      input  o, o_top, count, empty, full, ovf, unf
   );

   modport slave (
      input  clr, push, pop, i,
      output o, o_top, count, empty, full, ovf, unf
   );
endinterface

// File: rtl/seq_hist_reg.sv
// LIFO history register for LSTM forward/BPTT passes. Forward steps push
// one vector per time step. The backward pass pops them newest-first.
//
// Handshake: push and pop are single-cycle strobes with no ready/back-pressure.
// The register accepts every strobe on the rising edge where it is high.
// A push while full drops the oldest slot and sets sticky ovf. A pop while
// empty changes nothing but sets sticky unf. push+pop together replaces the
// newest entry. The newest entry is always visible on o_top, so a pop
// consumes what o_top shows in that same cycle.
module seq_hist_reg #(
   parameter int NUM_ITERATIONS = 68,
   parameter int WIDTH          = 32,
   parameter int NUM_CH         = 1,
   localparam int CW            = $clog2(NUM_ITERATIONS + 1)
) (
   input logic             clk,
   input logic             rst,
   seq_hist_reg_if.slave   bus
);
   localparam int VW = NUM_CH * WIDTH;
   localparam logic [CW-1:0] FULL_CNT = CW'(NUM_ITERATIONS);

   // Slot NUM_ITERATIONS-1 is the newest entry. Valid entries fill the top
   // `count` slots, and the slots below them are held at zero.
   logic [VW-1:0] slot_q [NUM_ITERATIONS];
   logic [CW-1:0] count_q;
   logic          ovf_q;
   logic          unf_q;

   logic is_empty;
   logic is_full;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == FULL_CNT);

   // Storage, occupancy and sticky flags. Priority is rst, then clr, then push/pop.
   always_ff @(posedge clk) begin
      if (rst || bus.clr) begin
         for (int k = 0; k < NUM_ITERATIONS; k++) slot_q[k] <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (bus.push && bus.pop && !is_empty) begin
         // Replace newest in place. The count is unchanged, even when full.
         slot_q[NUM_ITERATIONS-1] <= bus.i;
      end else if (bus.push) begin
         for (int k = 0; k < NUM_ITERATIONS - 1; k++) slot_q[k] <= slot_q[k+1];
         slot_q[NUM_ITERATIONS-1] <= bus.i;
         if (is_full) ovf_q <= 1'b1;
         else         count_q <= count_q + CW'(1);
      end else if (bus.pop) begin
         if (is_empty) begin
            unf_q <= 1'b1;
         end else begin
            for (int k = 0; k < NUM_ITERATIONS - 1; k++) slot_q[k+1] <= slot_q[k];
            slot_q[0] <= '0;
            count_q   <= count_q - CW'(1);
         end
      end
   end

   // Flatten the slots onto the parallel output bus.
   for (genvar k = 0; k < NUM_ITERATIONS; k++) begin : g_out
      assign bus.o[(k+1)*VW-1 -: VW] = slot_q[k];
   end

   assign bus.o_top = slot_q[NUM_ITERATIONS-1];
   assign bus.count = count_q;
   assign bus.empty = is_empty;
   assign bus.full  = is_full;
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;
endmodule

// File: tb/tb_seq_hist_reg.sv
// Bench for seq_hist_reg at depth 4, 8-bit words, one channel.
// The directed table covers reset, fill/overflow, drain/underflow,
// replace-newest, and clear priority. A random phase follows, checked
// against a queue-based LIFO model.
module tb_seq_hist_reg;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = N*W + W + 3 + 4;

   logic clk;
   logic rst;

   seq_hist_reg_if #(.NUM_ITERATIONS(N), .WIDTH(W), .NUM_CH(1)) bus ();

   seq_hist_reg #(.NUM_ITERATIONS(N), .WIDTH(W), .NUM_CH(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          r;
      logic          c;
      logic          pu;
      logic          po;
      logic [W-1:0]  d;
      logic [N*W-1:0] eo;
      logic [2:0]    ec;
      logic          eovf;
      logic          eunf;
   } vec_t;

   vec_t           tbl[$];
   logic [SW-1:0]  exp_q[$];
   int             n_tests;
   int             n_fail;

   // reference LIFO model: lst[$] newest at back
   logic [W-1:0]   lst[$];
   logic           movf;
   logic           munf;

   function automatic vec_t mk(input logic r, input logic c, input logic pu, input logic po,
                               input logic [W-1:0] d, input logic [N*W-1:0] eo,
                               input logic [2:0] ec, input logic eovf, input logic eunf);
      vec_t v;
      v.r = r; v.c = c; v.pu = pu; v.po = po; v.d = d;
      v.eo = eo; v.ec = ec; v.eovf = eovf; v.eunf = eunf;
      return v;
   endfunction

   function automatic logic [SW-1:0] pack_exp(input logic [N*W-1:0] eo, input logic [2:0] ec,
                                              input logic eovf, input logic eunf);
      return {eo, eo[N*W-1 -: W], ec, (ec == 3'd0), (ec == 3'(N)), eovf, eunf};
   endfunction

   function automatic logic [SW-1:0] actual();
      return {bus.o, bus.o_top, bus.count, bus.empty, bus.full, bus.ovf, bus.unf};
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input logic r, input logic c, input logic pu, input logic po,
                        input logic [W-1:0] d);
      rst      = r;
      bus.clr  = c;
      bus.push = pu;
      bus.pop  = po;
      bus.i    = d;
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check_out(input string name);
      logic [SW-1:0] e;
      logic [SW-1:0] a;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty", name);
         return;
      end
      e = exp_q.pop_front();
      a = actual();
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got o=%h top=%h cnt=%0d e/f=%b%b ovf=%b unf=%b, want o=%h top=%h cnt=%0d e/f=%b%b ovf=%b unf=%b",
                  name, a[SW-1 -: N*W], a[W+6 -: W], a[6:4], a[3], a[2], a[1], a[0],
                  e[SW-1 -: N*W], e[W+6 -: W], e[6:4], e[3], e[2], e[1], e[0]);
      end
   endtask

   task automatic check_top(input string name, input logic [W-1:0] want);
      n_tests++;
      if (bus.o_top !== want) begin
         n_fail++;
         $display("FAIL %s: o_top before pop got %h want %h", name, bus.o_top, want);
      end
   endtask

   // model step: returns packed expected state after applying inputs
   task automatic model_step(input logic r, input logic c, input logic pu, input logic po,
                             input logic [W-1:0] d, output logic [SW-1:0] e);
      logic [N*W-1:0] eo;
      int             base;
      logic [W-1:0]   junk;
      if (r || c) begin
         lst.delete();
         movf = 1'b0;
         munf = 1'b0;
      end else if (pu && po && lst.size() != 0) begin
         lst[lst.size()-1] = d;
      end else if (pu) begin
         lst.push_back(d);
         if (lst.size() > N) begin
            junk = lst.pop_front();
            movf = 1'b1;
         end
      end else if (po) begin
         if (lst.size() == 0) munf = 1'b1;
         else junk = lst.pop_back();
      end
      eo   = '0;
      base = N - lst.size();
      for (int k = 0; k < N; k++)
         if (k >= base) eo[k*W +: W] = lst[k-base];
      e = pack_exp(eo, 3'(lst.size()), movf, munf);
   endtask

   // ---------------- main ----------------
   initial begin
      n_tests = 0;
      n_fail  = 0;
      movf    = 1'b0;
      munf    = 1'b0;
      rst = 1'b1; bus.clr = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.i = '0;
      repeat (2) @(posedge clk);
      #1;

      //        r  c  pu po  d      expected o       cnt ovf unf
      tbl.push_back(mk(0, 0, 1, 0, 8'hAA, 32'hAA000000, 3'd1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'hBB, 32'hBBAA0000, 3'd2, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 8'hCC, 32'h00000000, 3'd0, 0, 0)); // reset beats push
      tbl.push_back(mk(0, 0, 1, 0, 8'h11, 32'h11000000, 3'd1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'h22, 32'h22110000, 3'd2, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'h33, 32'h33221100, 3'd3, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'h44, 32'h44332211, 3'd4, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'h55, 32'h55443322, 3'd4, 1, 0)); // overflow
      tbl.push_back(mk(0, 0, 0, 1, 8'h00, 32'h44332200, 3'd3, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 8'h00, 32'h33220000, 3'd2, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 8'h00, 32'h22000000, 3'd1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 8'h00, 32'h00000000, 3'd0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 8'h00, 32'h00000000, 3'd0, 1, 1)); // underflow
      tbl.push_back(mk(0, 1, 0, 0, 8'h00, 32'h00000000, 3'd0, 0, 0)); // clear
      tbl.push_back(mk(0, 0, 1, 0, 8'h22, 32'h22000000, 3'd1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'h33, 32'h33220000, 3'd2, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 8'h7F, 32'h7F220000, 3'd2, 0, 0)); // replace newest
      tbl.push_back(mk(0, 0, 0, 1, 8'h00, 32'h22000000, 3'd1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 8'h00, 32'h00000000, 3'd0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 8'h80, 32'h80000000, 3'd1, 0, 0)); // push+pop on empty
      tbl.push_back(mk(0, 0, 1, 0, 8'h01, 32'h01800000, 3'd2, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'h02, 32'h02018000, 3'd3, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'h03, 32'h03020180, 3'd4, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'h04, 32'h04030201, 3'd4, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 8'h00, 32'h03020100, 3'd3, 1, 0));
      tbl.push_back(mk(0, 1, 1, 0, 8'h99, 32'h00000000, 3'd0, 0, 0)); // clr beats push
      tbl.push_back(mk(0, 0, 1, 0, 8'h5A, 32'h5A000000, 3'd1, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 8'h00, 32'h00000000, 3'd0, 0, 0)); // rst+clr
      tbl.push_back(mk(0, 0, 1, 0, 8'hA1, 32'hA1000000, 3'd1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'hA2, 32'hA2A10000, 3'd2, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'hA3, 32'hA3A2A100, 3'd3, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'hA4, 32'hA4A3A2A1, 3'd4, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 8'hB0, 32'hB0A3A2A1, 3'd4, 0, 0)); // replace when full
      tbl.push_back(mk(0, 0, 0, 0, 8'hEE, 32'hB0A3A2A1, 3'd4, 0, 0)); // idle holds

      // reset-state check after the initial reset
      exp_q.push_back(pack_exp(32'h0, 3'd0, 1'b0, 1'b0));
      check_out("reset_state");

      for (int r = 0; r < tbl.size(); r++) begin
         if (tbl[r].po && r > 0)
            check_top($sformatf("row%0d_pre_top", r), tbl[r-1].eo[N*W-1 -: W]);
         exp_q.push_back(pack_exp(tbl[r].eo, tbl[r].ec, tbl[r].eovf, tbl[r].eunf));
         drive(tbl[r].r, tbl[r].c, tbl[r].pu, tbl[r].po, tbl[r].d);
         check_out($sformatf("row%0d", r));
      end

      // random phase: start from a known reset state in both DUT and model
      begin
         logic [SW-1:0] e;
         model_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, e);
         exp_q.push_back(e);
         drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
         check_out("rand_reset");
         for (int n = 0; n < 1000; n++) begin
            logic         c, pu, po;
            logic [W-1:0] d;
            c  = ($urandom_range(0, 49) == 0);
            pu = $urandom_range(0, 1);
            po = $urandom_range(0, 1);
            d  = W'($urandom_range(0, 255));
            if (po && lst.size() != 0)
               check_top($sformatf("rand%0d_pre_top", n), lst[lst.size()-1]);
            model_step(1'b0, c, pu, po, d, e);
            exp_q.push_back(e);
            drive(1'b0, c, pu, po, d);
            check_out($sformatf("rand%0d", n));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
